crc16_frame_packer: RTL and testbench
=====================================

Name: crc16_frame_packer

Overview:
- Stage directly upstream of the CRC16 engine (poly 1+x^5+x^12+x^16, 16-bit parallel, seed 0x0000).
- Collects one payload frame of 16-bit words into an internal buffer, then replays it to the engine with crc valid held high for exactly N contiguous cycles. The engine clears its state whenever valid is low, so the replay must have no gaps.
- Captures the engine result on its done pulse.
- Emits a framed stream downstream: length word, payload words, CRC word.

Parameters:
- MAX_WORDS, 16, payload buffer depth in words; legal range 1..256.
- LEN_W, 8, width of the internal word counter; must satisfy 2^LEN_W > MAX_WORDS+1.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  16  payload word.
- in_valid  input  1  payload word valid.
- in_last  input  1  final word of frame; qualified by in_valid.
- in_ready  output  1  packer accepts a word this cycle.
- crc_data_o  output  16  word to CRC engine data input.
- crc_valid_o  output  1  CRC engine valid.
- crc_result_i  input  16  CRC engine result.
- crc_done_i  input  1  CRC engine done pulse.
- out_data  output  16  framed output word.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks the CRC word.
- out_ready  input  1  downstream accepts.
- err_overflow  output  1  one-cycle pulse: frame dropped because it exceeded MAX_WORDS.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; counters=0; crc register=0x0000.
  - All outputs 0: in_ready, crc_valid_o, crc_data_o, out_valid, out_data, out_last, err_overflow.
- Handshakes:
  - Input beat transfers when in_valid & in_ready.
  - Output beat transfers when out_valid & out_ready.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- IDLE/LOAD:
  - in_ready=1.
  - Each accepted beat writes buf[wr_cnt] and increments wr_cnt.
  - A beat with in_last=1 latches N=wr_cnt+1, clears in_ready from the next cycle, and moves to CALC.
  - Input bubbles in LOAD are legal.
- Overflow:
  - An accepted beat when wr_cnt==MAX_WORDS enters DROP. Nothing is written.
  - DROP keeps in_ready=1 and discards beats up to and including in_last.
  - On that in_last beat: err_overflow pulses for one cycle and state returns to IDLE. Nothing is emitted to CRC or output.
  - A frame of exactly MAX_WORDS is legal.
- CALC:
  - crc_valid_o=1 for exactly N consecutive cycles; crc_data_o=buf[0..N-1], one per cycle.
  - crc_data_o and crc_valid_o are registered outputs.
  - The cycle after the last word enters WAIT with crc_valid_o=0 and crc_data_o=0.
- WAIT:
  - On crc_done_i=1, latch crc_result_i into the crc register and go to SEND.
  - The engine asserts done in the first WAIT cycle; the packer waits indefinitely regardless.
  - crc_done_i in any other state is ignored.
- SEND: beats 0..N+1 with out_valid=1.
  - Beat 0: zero-extended N.
  - Beats 1..N: buf[0..N-1].
  - Beat N+1: crc register, out_last=1.
  - After the beat N+1 handshake: out_valid=0, state returns to IDLE, in_ready=1 the next cycle.
- in_ready=0 throughout CALC, WAIT and SEND; no new frame overlaps.
- Latency, from in_last accepted to first out_valid: N+2 cycles, i.e. N CALC cycles plus 1 WAIT cycle plus 1 register cycle. Latency is fixed and independent of out_ready.
- Reset asserted mid-operation, in any state, aborts the frame immediately. Buffer contents need not be cleared; counters are cleared.

Test Plan:
- Single word 0x0001 with in_last, out_ready=1:
  - crc_valid_o high exactly 1 cycle with crc_data_o=0x0001.
  - Output 0x0001, 0x0001, 0x1021 (out_last on the third beat).
- Two words 0x0001 then 0x0000:
  - crc_valid_o high 2 contiguous cycles.
  - Output 0x0002, 0x0001, 0x0000, 0x3730.
  - First out_valid exactly 4 cycles after in_last accepted.
- MAX_WORDS=16 frame of words 0x0000..0x000F, with random out_ready stalls and input bubbles:
  - Output length 0x0010, payload in order, CRC equal to a software model.
  - Data stable during stalls; no crc_valid_o gap.
- 17-word frame:
  - err_overflow pulses once, on the in_last beat.
  - No crc_valid_o, no out_valid.
  - A following 1-word frame 0x0001 produces 0x0001, 0x0001, 0x1021.
- Reset asserted during CALC of a 5-word frame:
  - crc_valid_o, out_valid and in_ready go to 0 asynchronously.
  - After release, in_ready=1 and a 1-word frame 0x0000 produces 0x0001, 0x0000, 0x0000.
- Back-to-back frames with in_valid held high:
  - in_ready stays 0 from CALC until the CRC-word handshake.
  - The second frame is accepted only afterwards, and both frames' outputs match the model.

Source files
------------

// File: rtl/crc16_frame_packer.sv
// Buffers one frame of 16-bit words, replays it gap-free to an external CRC16 engine,
// then emits length word, payload and captured CRC downstream.
module crc16_frame_packer #(
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned LEN_W     = 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] crc_data_o,
    output logic        crc_valid_o,
    input  logic [15:0] crc_result_i,
    input  logic        crc_done_i,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        err_overflow
);

    localparam int unsigned IdxW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned Depth = 2 ** IdxW;
    localparam logic [LEN_W-1:0] MaxCnt = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] One    = LEN_W'(1);

    typedef enum logic [2:0] {StIdle, StLoad, StDrop, StCalc, StWait, StSend} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [15:0]        crc_q, crc_d;
    logic               in_ready_q, in_ready_d;
    logic               crc_valid_q, crc_valid_d;
    logic [15:0]        crc_data_q, crc_data_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               mem_we;
    logic               accept;
    logic [IdxW-1:0]    wr_idx, rd_idx;
    logic [15:0]        mem_q [Depth];

    assign accept = in_valid & in_ready_q;
    assign wr_idx = wr_cnt_q[IdxW-1:0];
    assign rd_idx = rd_cnt_q[IdxW-1:0];

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[wr_idx] <= in_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        n_d          = n_q;
        crc_d        = crc_q;
        crc_valid_d  = 1'b0;
        crc_data_d   = 16'h0000;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        mem_we       = 1'b0;
        err_overflow = 1'b0;

        unique case (state_q)
            StIdle, StLoad: begin
                if (accept) begin
                    if (wr_cnt_q == MaxCnt) begin
                        wr_cnt_d = '0;
                        if (in_last) begin
                            err_overflow = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            state_d = StDrop;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + One;
                        state_d  = StLoad;
                        if (in_last) begin
                            // First replay word is launched here; bypass the buffer for 1-word frames
                            n_d         = wr_cnt_q + One;
                            wr_cnt_d    = '0;
                            rd_cnt_d    = One;
                            crc_valid_d = 1'b1;
                            crc_data_d  = (wr_cnt_q == '0) ? in_data : mem_q[0];
                            state_d     = StCalc;
                        end
                    end
                end
            end
            StDrop: begin
                if (accept && in_last) begin
                    err_overflow = 1'b1;
                    state_d      = StIdle;
                end
            end
            StCalc: begin
                if (rd_cnt_q < n_q) begin
                    crc_valid_d = 1'b1;
                    crc_data_d  = mem_q[rd_idx];
                    rd_cnt_d    = rd_cnt_q + One;
                end else begin
                    rd_cnt_d = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (crc_done_i) begin
                    crc_d       = crc_result_i;
                    out_valid_d = 1'b1;
                    out_data_d  = 16'(n_q);
                    out_last_d  = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_data_d  = 16'h0000;
                        out_last_d  = 1'b0;
                        rd_cnt_d    = '0;
                        state_d     = StIdle;
                    end else if (rd_cnt_q < n_q) begin
                        out_data_d = mem_q[rd_idx];
                        rd_cnt_d   = rd_cnt_q + One;
                    end else begin
                        out_data_d = crc_q;
                        out_last_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StDrop);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            n_q         <= '0;
            crc_q       <= 16'h0000;
            in_ready_q  <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            n_q         <= n_d;
            crc_q       <= crc_d;
            in_ready_q  <= in_ready_d;
            crc_valid_q <= crc_valid_d;
            crc_data_q  <= crc_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign crc_valid_o = crc_valid_q;
    assign crc_data_o  = crc_data_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_crc16_frame_packer.sv
// Directed bench for crc16_frame_packer with a behavioural CRC16 engine stub.
module tb_crc16_frame_packer;

    localparam int MaxWords = 16;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] crc_data_o;
    logic        crc_valid_o;
    logic [15:0] crc_result_i;
    logic        crc_done_i;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        err_overflow;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    bit stall_mode = 1'b0;

    crc16_frame_packer #(
        .MAX_WORDS(MaxWords),
        .LEN_W    (8)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .crc_data_o  (crc_data_o),
        .crc_valid_o (crc_valid_o),
        .crc_result_i(crc_result_i),
        .crc_done_i  (crc_done_i),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .err_overflow(err_overflow)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] w[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (w[i]) c = crc_step(c, w[i]);
        return c;
    endfunction

    // Engine stub: accumulates while valid, clears when idle, done in the first idle cycle
    logic        eng_prev = 1'b0;
    logic [15:0] eng_acc  = 16'h0000;
    always @(posedge clk_in) begin
        eng_prev <= crc_valid_o;
        if (crc_valid_o) eng_acc <= crc_step(eng_acc, crc_data_o);
        else             eng_acc <= 16'h0000;
    end
    assign crc_done_i   = eng_prev & ~crc_valid_o;
    assign crc_result_i = eng_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor state
    logic [16:0] out_q[$];
    logic [15:0] cv_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'h0000;
    logic        prev_last  = 1'b0;
    logic        prev_ov    = 1'b0;
    logic        prev_cv    = 1'b0;
    logic        busy       = 1'b0;
    int          in_words   = 0;
    int          cv_high    = 0;
    int          cv_runs    = 0;
    int          err_cnt    = 0;
    int          ov_rise_cyc = 0;

    always @(negedge clk_in) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            prev_stall <= out_valid & ~out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
            if (out_valid && out_ready) begin
                out_q.push_back({out_last, out_data});
                if (out_last) busy <= 1'b0;
            end
            if (out_valid && !prev_ov) ov_rise_cyc <= cyc;
            prev_ov <= out_valid;
            if (crc_valid_o) begin
                cv_q.push_back(crc_data_o);
                cv_high <= cv_high + 1;
                if (!prev_cv) cv_runs <= cv_runs + 1;
            end
            prev_cv <= crc_valid_o;
            if (err_overflow) begin
                err_cnt <= err_cnt + 1;
                check("err_on_last", {in_valid, in_last}, 3);
            end
            if (busy) check("in_ready_busy", in_ready, 0);
            if (in_valid && in_ready) begin
                if (in_last) begin
                    in_words <= 0;
                    if (in_words < MaxWords) busy <= 1'b1;
                end else begin
                    in_words <= in_words + 1;
                end
            end
        end else begin
            prev_stall <= 1'b0;
            prev_ov    <= 1'b0;
            prev_cv    <= 1'b0;
            busy       <= 1'b0;
            in_words   <= 0;
        end
    end

    task automatic push_word(input logic [15:0] d, input bit last);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk_in);
        while (!in_ready && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        check("in_accept", in_ready, 1);
        if (last) last_acc_cyc = cyc;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_last();
        bit seen;
        int t;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 1000) begin
            out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk_in);
            if (out_valid && out_ready && out_last) seen = 1'b1;
            @(posedge clk_in);
            #1;
            t++;
        end
        out_ready = 1'b1;
        check("frame_end", seen, 1);
    endtask

    task automatic expect_frame(input logic [15:0] w[$], input logic [15:0] ecrc, input int base,
                                input string tag);
        int n;
        n = w.size();
        check({tag, "_len_word"}, out_q[base], {1'b0, 16'(n)});
        foreach (w[i]) check({tag, "_payload"}, out_q[base + 1 + i], {1'b0, w[i]});
        check({tag, "_crc_word"}, out_q[base + n + 1], {1'b1, ecrc});
    endtask

    task automatic run_frame(input logic [15:0] w[$], input bit stalls, input bit bubbles,
                             input logic [15:0] ecrc, input string tag);
        int ob, cb, cvh0, cvr0;
        ob = out_q.size();
        cb = cv_q.size();
        cvh0 = cv_high;
        cvr0 = cv_runs;
        stall_mode = stalls;
        foreach (w[i]) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk_in);
                #1;
            end
            push_word(w[i], i == w.size() - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_last();
        stall_mode = 1'b0;
        check({tag, "_cv_runs"}, cv_runs - cvr0, 1);
        check({tag, "_cv_cycles"}, cv_high - cvh0, w.size());
        foreach (w[i]) check({tag, "_cv_data"}, cv_q[cb + i], w[i]);
        check({tag, "_out_beats"}, out_q.size() - ob, w.size() + 2);
        expect_frame(w, ecrc, ob, tag);
        check({tag, "_latency"}, ov_rise_cyc - last_acc_cyc, w.size() + 2);
    endtask

    logic [15:0] wa[$];
    logic [15:0] wb[$];

    initial begin
        int e0, cvh0, ob;
        rst       = 1'b1;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_in_ready", in_ready, 0);
        check("rst_crc_valid", crc_valid_o, 0);
        check("rst_crc_data", crc_data_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err_overflow, 0);
        @(posedge clk_in);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Single word
        wa = {16'h0001};
        run_frame(wa, 1'b0, 1'b0, 16'h1021, "one_word");

        // Two words, latency 4
        wa = {16'h0001, 16'h0000};
        run_frame(wa, 1'b0, 1'b0, 16'h3730, "two_words");

        // Full MAX_WORDS frame with stalls and bubbles
        wa = {};
        for (int i = 0; i < MaxWords; i++) wa.push_back(16'(i));
        run_frame(wa, 1'b1, 1'b1, crc_model(wa), "full_frame");

        // 17-word frame is dropped
        e0   = err_cnt;
        cvh0 = cv_high;
        ob   = out_q.size();
        for (int i = 0; i <= MaxWords; i++) push_word(16'(i), i == MaxWords);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (25) @(posedge clk_in);
        #1;
        check("ovf_err_pulses", err_cnt - e0, 1);
        check("ovf_no_crc_valid", cv_high - cvh0, 0);
        check("ovf_no_output", out_q.size() - ob, 0);
        wa = {16'h0001};
        run_frame(wa, 1'b0, 1'b0, 16'h1021, "after_ovf");

        // Reset during CALC of a 5-word frame
        for (int i = 1; i <= 5; i++) push_word(16'(i), i == 5);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("calc_before_rst", crc_valid_o, 1);
        rst = 1'b1;
        #1;
        check("async_rst_crc_valid", crc_valid_o, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk_in);
        #2;
        rst = 1'b0;
        @(posedge clk_in);
        #1;
        check("rel_in_ready", in_ready, 1);
        wa = {16'h0000};
        run_frame(wa, 1'b0, 1'b0, 16'h0000, "after_rst");

        // Back-to-back frames with in_valid held high
        wa = {16'h1234, 16'hABCD, 16'h0F0F};
        wb = {16'h0001, 16'h8000};
        ob = out_q.size();
        foreach (wa[i]) push_word(wa[i], i == wa.size() - 1);
        foreach (wb[i]) push_word(wb[i], i == wb.size() - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_last();
        check("b2b_out_beats", out_q.size() - ob, wa.size() + wb.size() + 4);
        expect_frame(wa, crc_model(wa), ob, "b2b_first");
        expect_frame(wb, crc_model(wb), ob + wa.size() + 2, "b2b_second");
        check("b2b_latency", ov_rise_cyc - last_acc_cyc, wb.size() + 2);

        repeat (3) @(posedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
